// File: rtl/sync_fifo_if.sv
// Handshake/data bundle between a FIFO and its producer/consumer.
interface sync_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                  flush;
  logic                  wren;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  rden;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wren, i_data, rden, clr_err,
    input  o_data, o_valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  flush, wren, i_data, rden, clr_err,
    output o_data, o_valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, any depth, standard or first-word-fall-through read,
// occupancy count, threshold flags, sticky error flags and synchronous flush.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AF_THRESH  = DEPTH - 1,
  parameter int unsigned AE_THRESH  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  sync_fifo_if.slave  bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic full_c, empty_c, rd_acc_c, wr_acc_c;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Status decodes of the registered count; flush blocks any access.
  assign full_c   = (count_q == CW'(DEPTH));
  assign empty_c  = (count_q == '0);
  assign rd_acc_c = !bus.flush && bus.rden && !empty_c;
  assign wr_acc_c = !bus.flush && bus.wren && (!full_c || rd_acc_c);

  assign bus.count        = count_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

  // Pointer, occupancy and error-flag next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q && !bus.clr_err;
    unf_d    = unf_q && !bus.clr_err;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc_c) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc_c) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (wr_acc_c && !rd_acc_c)      count_d = count_q + CW'(1);
      else if (rd_acc_c && !wr_acc_c) count_d = count_q - CW'(1);
      if (bus.wren && !wr_acc_c) ovf_d = 1'b1;
      if (bus.rden && empty_c)   unf_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_c) mem_q[wr_ptr_q] <= bus.i_data;
  end

  if (FWFT == 0) begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    // Registered read: one-cycle valid pulse per accepted pop, data holds otherwise.
    always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      if (rd_acc_c) begin
        rdata_d  = mem_q[rd_ptr_q];
        rvalid_d = 1'b1;
      end
    end

    // Read output registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign bus.o_data  = rdata_q;
    assign bus.o_valid = rvalid_q;
  end else begin : g_fwft
    assign bus.o_data  = mem_q[rd_ptr_q];
    assign bus.o_valid = !empty_c;
  end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised synchronous FIFO: any integer depth (not only powers of two), arbitrary data width, and selectable standard or first-word-fall-through read mode. It adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It is the general-purpose buffer between single-clock producer and consumer blocks and replaces fixed 8x8 FIFO instances.

## Interface
- DATA_WIDTH, 8, width of i_data/o_data (>=1)
- DEPTH, 8, number of entries, any integer >=2
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- AF_THRESH, DEPTH-1, almost_full asserted when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
- CW (localparam), $clog2(DEPTH+1), count width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of contents
- wren  in  1  write request
- i_data  in  DATA_WIDTH  write data
- rden  in  1  read request (pop)
- o_data  out  DATA_WIDTH  read data
- o_valid  out  1  o_data valid qualifier
- count  out  CW  current occupancy, 0..DEPTH
- full / empty  out  1  count==DEPTH / count==0
- almost_full / almost_empty  out  1  threshold flags
- overflow / underflow  out  1  sticky error flags
- clr_err  in  1  synchronous clear of overflow/underflow

## Operation
- State: mem[DEPTH], wr_ptr and rd_ptr (0..DEPTH-1), count register. The memory is not reset.
- Pointer wrap: a pointer at DEPTH-1 advances to 0 explicitly, with no modulo-2^n assumption.
- rd_acc = rden && !empty. There is no bypass, so a read of an empty FIFO is never accepted, even with a concurrent write.
- wr_acc = wren && (!full || rd_acc). A write to a full FIFO is accepted only alongside an accepted read.
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither occur.
- full, empty, almost_full and almost_empty are combinational decodes of the registered count.
- overflow is set on wren && !wr_acc. underflow is set on rden && empty.
- Both error flags hold until clr_err. If a set condition and clr_err coincide, the flag is set.
- flush clears wr_ptr, rd_ptr and count to 0, and clears o_valid in FWFT=0.
  - flush overrides wren/rden in the same cycle: nothing is written or read, and no error is flagged.
  - flush does not clear overflow/underflow.
- FWFT=0:
  - On rd_acc, o_data <= mem[rd_ptr] and o_valid <= 1 for exactly one cycle.
  - Otherwise o_valid <= 0 and o_data holds its last value.
- FWFT=1:
  - o_data = mem[rd_ptr] combinationally and o_valid = !empty. rden pops the head.
  - o_data is don't-care while empty.
- Reset values: count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, o_valid 0, o_data 0 (FWFT=0). Pointers are 0.
- Reset mid-operation discards all contents immediately, with no clock required.

## Timing
- Write: data accepted on edge N is counted at N+1 (count, flags) and is readable from N+1.
- FWFT=0 read latency: rden at edge N gives o_data/o_valid valid after N, sampled at N+1.
- FWFT=1: the head is visible the cycle after it is written, i.e. first-word latency of 1.
- Simultaneous rd_acc/wr_acc at count==DEPTH: the head is read, the new word is stored in the freed slot, full stays 1 and no overflow is flagged.
- Simultaneous rden/wren at count==0: the write is stored, the read is rejected, underflow is set and count becomes 1.
- Back-to-back rden for DEPTH cycles from full gives DEPTH consecutive o_valid pulses. empty asserts the cycle after the last accept.

## Test plan
- Reset with DEPTH=5, FWFT=0: write 0x11..0x55 on 5 consecutive cycles, then 5 reads. Required: full=1 with count=5 after the writes, o_data sequence 0x11..0x55 with o_valid high 5 cycles, then empty=1.
- Wrap with DEPTH=5: run 3 cycles of write 3 / read 3. Required: pointers wrap past 4 to 0, data order is preserved, count returns to 0 each cycle, and there are no errors.
- Full plus concurrent read/write: at count=5, assert wren (0xA0) and rden together. Required: the head is output, count stays 5, overflow=0, and 0xA0 is the last word read.
- Errors: wren alone at full sets overflow. rden at empty sets underflow. Both persist until clr_err; clr_err coincident with a new overflow leaves overflow=1.
- Thresholds with AF_THRESH=4, AE_THRESH=1: count 0->5->0. Required: almost_full high for count in 4..5, almost_empty high for count in 0..1, updated 1 cycle after each accept.
- FWFT=1: write 0x3C to an empty FIFO. Required: o_valid=1 and o_data=0x3C the next cycle, before any rden; rden then gives empty=1. Then flush at count=3 with wren=1: required count=0 and the write dropped. Async rst_n pulse mid-stream: required reset values immediately.
